// File: rtl/i2s_slave_port.sv
// i2s_slave_port: I2S slave endpoint that follows host BCLK/LRCLK, captures host TX I/Q from din
// and serialises frame-coherent receiver I/Q onto dout once framing is locked.
module i2s_slave_port #(
   parameter int RX_WIDTH = 24,
   parameter int TX_WIDTH = 16,
   parameter int TIMEOUT  = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                bclk_in,
   input  logic                lrclk_in,
   input  logic                din,
   output logic                dout,
   input  logic [RX_WIDTH-1:0] rx_real,
   input  logic [RX_WIDTH-1:0] rx_imag,
   output logic                rx_strobe,
   output logic [TX_WIDTH-1:0] tx_real,
   output logic [TX_WIDTH-1:0] tx_imag,
   output logic                tx_valid,
   output logic                locked
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int OW = $clog2(RX_WIDTH + 1);
   localparam logic [5:0] TXW = 6'(TX_WIDTH);
   localparam logic [6:0] MIN_LEN = 7'((RX_WIDTH > TX_WIDTH ? RX_WIDTH : TX_WIDTH) + 1);
   localparam logic [OW-1:0] RXW = OW'(RX_WIDTH);
   localparam logic [TW-1:0] TO = TW'(TIMEOUT);
   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
   state_t state, state_n;
   logic [2:0] bclk_s, lr_s, din_s, match_cnt;
   logic [5:0] bit_cnt, cnt_n;
   logic [6:0] slot_len, ref_len;
   logic [TW-1:0] to_cnt;
   logic [OW-1:0] out_cnt;
   logic [TX_WIDTH-1:0] cap_sr, cap_n, hold_real;
   logic [RX_WIDTH-1:0] out_imag, out_sr, word;
   logic rise, fall, lr, lr_prev, boundary, timeout, cap_en, cap_last, len_ok;
   logic chan, first_fall, tx_pend;
   // LRCLK and DIN are taken from the edge-detect stage so they reflect the pins just before the BCLK edge
   assign rise = bclk_s[1] & ~bclk_s[2];
   assign fall = ~bclk_s[1] & bclk_s[2];
   assign lr = lr_s[2];
   assign boundary = rise & (lr != lr_prev);
   assign timeout = to_cnt == TO;
   assign cnt_n = boundary ? 6'd0 : (bit_cnt == 6'd63 ? bit_cnt : bit_cnt + 6'd1);
   assign slot_len = {1'b0, bit_cnt} + 7'd1;
   assign len_ok = slot_len == ref_len;
   assign cap_en = rise & (cnt_n != 6'd0) & (cnt_n <= TXW);
   assign cap_last = rise & (cnt_n == TXW);
   assign cap_n = {cap_sr[TX_WIDTH-2:0], din_s[2]};
   assign word = chan ? out_imag : rx_real;
   always_comb begin
      state_n = timeout ? HUNT :
                !boundary ? state :
                state == HUNT ? (lr ? HUNT : SYNC) :
                !len_ok ? HUNT :
                state == SYNC ? (match_cnt == 3'd3 ? LOCKED : SYNC) :
                slot_len < MIN_LEN ? HUNT : LOCKED;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bclk_s <= '0;
         lr_s <= '0;
         din_s <= '0;
         state <= HUNT;
         locked <= 1'b0;
         lr_prev <= 1'b0;
         bit_cnt <= '0;
         ref_len <= '0;
         match_cnt <= '0;
         to_cnt <= '0;
         cap_sr <= '0;
         hold_real <= '0;
         tx_real <= '0;
         tx_imag <= '0;
         tx_pend <= 1'b0;
         tx_valid <= 1'b0;
         chan <= 1'b0;
         first_fall <= 1'b0;
         out_imag <= '0;
         out_sr <= '0;
         out_cnt <= '0;
         dout <= 1'b0;
         rx_strobe <= 1'b0;
      end else begin
         bclk_s <= {bclk_s[1:0], bclk_in};
         lr_s <= {lr_s[1:0], lrclk_in};
         din_s <= {din_s[1:0], din};
         state <= state_n;
         locked <= state_n == LOCKED;
         to_cnt <= rise ? '0 : timeout ? to_cnt : to_cnt + TW'(1);
         rx_strobe <= 1'b0;
         tx_pend <= 1'b0;
         tx_valid <= tx_pend;
         if (boundary && state == HUNT && !lr) begin
            ref_len <= slot_len;
            match_cnt <= '0;
         end else if (boundary && state == SYNC && len_ok)
            match_cnt <= match_cnt + 3'd1;
         if (rise) begin
            lr_prev <= lr;
            bit_cnt <= cnt_n;
         end
         if (boundary) begin
            chan <= lr;
            first_fall <= 1'b1;
         end
         if (cap_en) cap_sr <= cap_n;
         if (cap_last && !lr) hold_real <= cap_n;
         // a frame only completes if lock held through its right-slot capture
         if (cap_last && lr && locked) begin
            tx_real <= hold_real;
            tx_imag <= cap_n;
            tx_pend <= 1'b1;
         end
         if (fall) begin
            first_fall <= 1'b0;
            if (first_fall) begin
               out_sr <= word;
               out_cnt <= OW'(1);
               dout <= word[RX_WIDTH-1];
               if (!chan && locked) begin
                  out_imag <= rx_imag;
                  rx_strobe <= 1'b1;
               end
            end else begin
               out_sr <= out_sr << 1;
               out_cnt <= out_cnt == RXW ? out_cnt : out_cnt + OW'(1);
               dout <= (out_cnt < RXW) & out_sr[RX_WIDTH-2];
            end
         end
         if (!locked) dout <= 1'b0;
      end
   end
endmodule

// File: tb/tb_i2s_slave_port.sv
// tb_i2s_slave_port: host-side I2S master model with scoreboarded TX words and host-sampled DOUT words.
module tb_i2s_slave_port;
   localparam int HB = 80;
   logic clk = 0, reset = 1, bclk_in = 0, lrclk_in = 0, din = 0, carry = 0;
   logic dout, rx_strobe, tx_valid, locked;
   logic [23:0] rx_real = 0, rx_imag = 0;
   logic [15:0] tx_real, tx_imag;
   int total = 0, bad = 0, strobes = 0;
   logic [31:0] exp_tx[$];
   logic [23:0] exp_rx[$], obs_rx[$];

   i2s_slave_port dut (
      .clk(clk), .reset(reset), .bclk_in(bclk_in), .lrclk_in(lrclk_in), .din(din), .dout(dout),
      .rx_real(rx_real), .rx_imag(rx_imag), .rx_strobe(rx_strobe), .tx_real(tx_real),
      .tx_imag(tx_imag), .tx_valid(tx_valid), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rx_strobe) strobes++;
      if (tx_valid) begin
         if (exp_tx.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_valid_unexpected: got %0h want none", {tx_real, tx_imag});
         end else chk("tx_word", {tx_real, tx_imag}, exp_tx.pop_front());
      end
      if (obs_rx.size() != 0 && exp_rx.size() != 0) chk("dout_word", obs_rx.pop_front(), exp_rx.pop_front());
   end

   task automatic run_slot(input logic ch, input logic [15:0] w, input int n, input int rst_at,
                           output logic [23:0] got, output logic tail, output logic lk);
      got = 0;
      tail = 0;
      lk = 0;
      for (int j = 0; j < n; j++) begin
         bclk_in = 0;
         lrclk_in = ch;
         din = carry;
         carry = (j < 16) ? w[15-j] : 1'b0;
         if (j == rst_at) begin
            #10 reset = 1;
            #1;
            chk("rst_tx", {tx_real, tx_imag}, 0);
            chk("rst_flags", {dout, rx_strobe, tx_valid, locked}, 0);
            #9 reset = 0;
            #(HB-20);
         end else #HB;
         bclk_in = 1;
         if (j >= 1 && j <= 24) got[24-j] = dout;
         else if (j > 24) tail |= dout;
         if (j == 2) lk = locked;
         #HB;
      end
   endtask

   task automatic frame(input logic [15:0] lw, input logic [15:0] rw, input int lbits,
                        input logic [23:0] rr, input logic [23:0] ri,
                        input logic lk_l, input logic lk_r, input logic mid, input int rst_at);
      logic [23:0] gl, gr;
      logic tl, tr, kl, kr;
      int s0;
      rx_real = rr;
      rx_imag = ri;
      s0 = strobes;
      if (lk_r) exp_tx.push_back({lw, rw});
      if (rst_at < 0) exp_rx.push_back(lk_l ? rr : 24'h0);
      run_slot(1'b0, lw, lbits, rst_at, gl, tl, kl);
      if (rst_at < 0) obs_rx.push_back(gl);
      if (mid) begin
         rx_real = ~rr;
         rx_imag = ~ri;
      end
      exp_rx.push_back(lk_r ? ri : 24'h0);
      run_slot(1'b1, rw, 32, -1, gr, tr, kr);
      obs_rx.push_back(gr);
      chk("lock_left", kl, lk_l);
      chk("lock_right", kr, lk_r);
      chk("dout_tail", {tl, tr}, 0);
      chk("strobe_count", strobes - s0, lk_l);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #20;
      chk("reset_tx", {tx_real, tx_imag}, 0);
      chk("reset_flags", {dout, rx_strobe, tx_valid, locked}, 0);
      #32 reset = 0;
      #50;
      repeat (3) frame(16'h8001, 16'h7FFE, 32, 24'hA5A5A5, 24'h5A5A5A, 0, 0, 0, -1);
      repeat (2) frame(16'h8001, 16'h7FFE, 32, 24'hA5A5A5, 24'h5A5A5A, 1, 1, 0, -1);
      frame(16'h0000, 16'hFFFF, 32, 24'h000001, 24'hFFFFFF, 1, 1, 0, -1);
      frame(16'h1234, 16'hABCD, 32, 24'h123456, 24'h654321, 1, 1, 1, -1);
      frame(16'hFFFF, 16'h0001, 32, 24'h800000, 24'h7FFFFF, 1, 1, 0, -1);
      frame(16'hC3C3, 16'h3C3C, 30, 24'hA5A5A5, 24'h5A5A5A, 1, 0, 0, -1);
      repeat (2) frame(16'h8001, 16'h7FFE, 32, 24'hA5A5A5, 24'h5A5A5A, 0, 0, 0, -1);
      frame(16'h0F0F, 16'hF0F0, 32, 24'h0F0F0F, 24'hF0F0F0, 1, 1, 0, -1);
      frame(16'h8001, 16'h7FFE, 32, 24'hA5A5A5, 24'h5A5A5A, 1, 1, 0, -1);
      frame(16'h5555, 16'hAAAA, 32, 24'h555555, 24'hAAAAAA, 1, 0, 0, 10);
      repeat (2) frame(16'h8001, 16'h7FFE, 32, 24'hA5A5A5, 24'h5A5A5A, 0, 0, 0, -1);
      frame(16'h7FFF, 16'h8000, 32, 24'h7FFFFF, 24'h800000, 1, 1, 0, -1);
      #10000;
      chk("lock_before_timeout", locked, 1);
      #1000;
      chk("lock_after_timeout", locked, 0);
      chk("dout_after_timeout", dout, 0);
      chk("tx_queue_empty", exp_tx.size(), 0);
      chk("rx_queue_empty", exp_rx.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
